// File: rtl/tlb_ctrl_pkg.sv
// Shared encodings and parameter defaults for the TLB op sequencer.
// The op_type encoding is the one WB presents on commit.
package tlb_ctrl_pkg;

  localparam int IDX_W_DEF      = 4;
  localparam int STARVE_MAX_DEF = 3;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_TLBP  = 2'b01,
    OP_TLBR  = 2'b10,
    OP_TLBWI = 2'b11
  } op_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

endpackage

// File: rtl/tlb_op_sequencer_if.sv
// Pipeline-facing bundle: fetch/mem translation requests and the WB TLB-op handshake.
// master = pipeline side, slave = sequencer side.
interface tlb_op_sequencer_if;
  import tlb_ctrl_pkg::*;

  logic        if_req;
  logic [19:0] if_vpn;
  logic        if_gnt;
  logic        mem_req;
  logic [19:0] mem_vpn;
  logic        mem_gnt;
  logic        op_valid;
  op_type_t    op_type;
  logic [31:0] op_pc;
  logic        op_ready;

  modport master (
    output if_req, if_vpn, mem_req, mem_vpn, op_valid, op_type, op_pc,
    input  if_gnt, mem_gnt, op_ready
  );

  modport slave (
    input  if_req, if_vpn, mem_req, mem_vpn, op_valid, op_type, op_pc,
    output if_gnt, mem_gnt, op_ready
  );

endinterface

// File: rtl/tlb_search_arb.sv
// IF/MEM arbitration for the shared TLB search port, with IF starvation promotion.
// Grants are combinational; hold (an executing TLB op) or reset blocks all grants.
module tlb_search_arb
  import tlb_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        if_req,
  input  logic [19:0] if_vpn,
  input  logic        mem_req,
  input  logic [19:0] mem_vpn,
  input  logic [7:0]  cp0_asid,
  output logic        if_gnt,
  output logic        mem_gnt,
  output logic [18:0] s_vpn2,
  output logic        s_odd,
  output logic [7:0]  s_asid
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             if_pri;
  logic             blocked;

  assign blocked = hold | reset;
  assign if_pri  = (starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    if_gnt  = 1'b0;
    mem_gnt = 1'b0;
    s_vpn2  = '0;
    s_odd   = 1'b0;
    s_asid  = '0;
    if (!blocked) begin
      if (if_req && (if_pri || !mem_req)) begin
        if_gnt = 1'b1;
      end else if (mem_req) begin
        mem_gnt = 1'b1;
      end
    end
    if (if_gnt) begin
      s_vpn2 = if_vpn[19:1];
      s_odd  = if_vpn[0];
      s_asid = cp0_asid;
    end else if (mem_gnt) begin
      s_vpn2 = mem_vpn[19:1];
      s_odd  = mem_vpn[0];
      s_asid = cp0_asid;
    end
  end

  // Frozen while an op executes so the blocked cycle does not count as starvation.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!hold) begin
      if (!if_req || if_gnt) begin
        starve_cnt <= '0;
      end else if (!if_pri) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tlb_op_sequencer.sv
// Sequences committed TLBP/TLBR/TLBWI through EXEC then FLUSH (refetch pc+4),
// owning the shared search port during EXEC and arbitrating IF/MEM otherwise.
module tlb_op_sequencer
  import tlb_ctrl_pkg::*;
#(
  parameter int IDX_W      = IDX_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  tlb_op_sequencer_if.slave  req_bus,
  input  logic [18:0]        cp0_vpn2,
  input  logic [7:0]         cp0_asid,
  output logic [18:0]        s_vpn2,
  output logic               s_odd,
  output logic [7:0]         s_asid,
  input  logic               s_found,
  input  logic [IDX_W-1:0]   s_index,
  output logic               p_wen,
  output logic               p_found,
  output logic [IDX_W-1:0]   p_index,
  output logic               tlb_we,
  output logic               cp0_tlbr,
  output logic               stall,
  output logic               refetch,
  output logic [31:0]        refetch_pc
);

  state_t      state;
  state_t      state_nxt;
  op_type_t    op_q;
  logic [31:0] pc_q;
  logic        accept;

  logic [18:0] a_vpn2;
  logic        a_odd;
  logic [7:0]  a_asid;

  tlb_search_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .hold     (state == ST_EXEC),
    .if_req   (req_bus.if_req),
    .if_vpn   (req_bus.if_vpn),
    .mem_req  (req_bus.mem_req),
    .mem_vpn  (req_bus.mem_vpn),
    .cp0_asid (cp0_asid),
    .if_gnt   (req_bus.if_gnt),
    .mem_gnt  (req_bus.mem_gnt),
    .s_vpn2   (a_vpn2),
    .s_odd    (a_odd),
    .s_asid   (a_asid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      op_q  <= OP_NONE;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= req_bus.op_type;
        pc_q <= req_bus.op_pc;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    accept           = 1'b0;
    req_bus.op_ready = 1'b0;
    s_vpn2           = a_vpn2;
    s_odd            = a_odd;
    s_asid           = a_asid;
    p_wen            = 1'b0;
    p_found          = 1'b0;
    p_index          = '0;
    tlb_we           = 1'b0;
    cp0_tlbr         = 1'b0;
    stall            = 1'b0;
    refetch          = 1'b0;
    refetch_pc       = '0;

    case (state)
      ST_IDLE: begin
        if (req_bus.op_valid && (req_bus.op_type != OP_NONE)) begin
          accept    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC:  state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    // Reset overrides everything, including whatever state the register holds.
    if (reset) begin
      req_bus.op_ready = 1'b1;
    end else begin
      req_bus.op_ready = (state == ST_IDLE);
      stall            = (state == ST_EXEC) || (state == ST_FLUSH);
      if (state == ST_EXEC) begin
        case (op_q)
          OP_TLBP: begin
            s_vpn2  = cp0_vpn2;
            s_odd   = 1'b0;
            s_asid  = cp0_asid;
            p_wen   = 1'b1;
            p_found = s_found;
            p_index = s_index;
          end
          OP_TLBR:  cp0_tlbr = 1'b1;
          OP_TLBWI: tlb_we   = 1'b1;
          default: ;
        endcase
      end
      if (state == ST_FLUSH) begin
        refetch    = 1'b1;
        refetch_pc = pc_q + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed self-checking bench for tlb_op_sequencer with hand-computed expectations.
module tb_tlb_op_sequencer;
  import tlb_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [18:0] cp0_vpn2;
  logic [7:0]  cp0_asid;
  logic [18:0] s_vpn2;
  logic        s_odd;
  logic [7:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index;
  logic        p_wen;
  logic        p_found;
  logic [3:0]  p_index;
  logic        tlb_we;
  logic        cp0_tlbr;
  logic        stall;
  logic        refetch;
  logic [31:0] refetch_pc;

  int checks;
  int failures;

  tlb_op_sequencer_if bus ();

  tlb_op_sequencer #(.IDX_W(4), .STARVE_MAX(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_bus    (bus),
    .cp0_vpn2   (cp0_vpn2),
    .cp0_asid   (cp0_asid),
    .s_vpn2     (s_vpn2),
    .s_odd      (s_odd),
    .s_asid     (s_asid),
    .s_found    (s_found),
    .s_index    (s_index),
    .p_wen      (p_wen),
    .p_found    (p_found),
    .p_index    (p_index),
    .tlb_we     (tlb_we),
    .cp0_tlbr   (cp0_tlbr),
    .stall      (stall),
    .refetch    (refetch),
    .refetch_pc (refetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.if_req   = 1'b1;
    bus.mem_req  = 1'b1;
    bus.if_vpn   = 20'hABCDE;
    bus.mem_vpn  = 20'h12345;
    bus.op_valid = 1'b1;
    bus.op_type  = OP_TLBWI;
    bus.op_pc    = 32'h0000_0100;
    next_cycle();
    #1;
    checks++; if (bus.op_ready !== 1'b1) begin failures++; $display("FAIL reset_op_ready got=%0h exp=1", bus.op_ready); end
    checks++; if ({bus.if_gnt, bus.mem_gnt, p_wen, p_found, tlb_we, cp0_tlbr, stall, refetch, s_odd} !== 9'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000000000", {bus.if_gnt, bus.mem_gnt, p_wen, p_found, tlb_we, cp0_tlbr, stall, refetch, s_odd});
    end
    checks++; if ({s_vpn2, s_asid, p_index, refetch_pc} !== 63'b0) begin
      failures++; $display("FAIL reset_buses got=%h exp=0", {s_vpn2, s_asid, p_index, refetch_pc});
    end
    next_cycle();
    reset        = 1'b0;
    bus.if_req   = 1'b0;
    bus.mem_req  = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_type  = OP_NONE;
    #1;
    checks++; if ({bus.op_ready, stall} !== 2'b10) begin failures++; $display("FAIL post_reset_idle got=%b exp=10", {bus.op_ready, stall}); end
  endtask

  task automatic test_tlbp;
    next_cycle();
    bus.op_valid = 1'b1;
    bus.op_type  = OP_TLBP;
    bus.op_pc    = 32'h0000_1000;
    cp0_vpn2     = 19'h00040;
    cp0_asid     = 8'h3A;
    s_found      = 1'b1;
    s_index      = 4'd5;
    #1;
    checks++; if (bus.op_ready !== 1'b1) begin failures++; $display("FAIL tlbp_accept_ready got=%0h exp=1", bus.op_ready); end
    next_cycle();
    bus.op_valid = 1'b0;
    #1;
    checks++; if ({p_wen, p_found, p_index} !== 6'b1_1_0101) begin failures++; $display("FAIL tlbp_result got=%b exp=110101", {p_wen, p_found, p_index}); end
    checks++; if ({s_vpn2, s_odd, s_asid} !== {19'h00040, 1'b0, 8'h3A}) begin failures++; $display("FAIL tlbp_search got=%h exp=%h", {s_vpn2, s_odd, s_asid}, {19'h00040, 1'b0, 8'h3A}); end
    checks++; if ({stall, bus.op_ready, tlb_we, cp0_tlbr, refetch} !== 5'b10000) begin failures++; $display("FAIL tlbp_exec_ctl got=%b exp=10000", {stall, bus.op_ready, tlb_we, cp0_tlbr, refetch}); end
    next_cycle();
    #1;
    checks++; if ({refetch, stall, p_wen} !== 3'b110) begin failures++; $display("FAIL tlbp_flush_ctl got=%b exp=110", {refetch, stall, p_wen}); end
    checks++; if (refetch_pc !== 32'h0000_1004) begin failures++; $display("FAIL tlbp_refetch_pc got=%h exp=00001004", refetch_pc); end
    next_cycle();
    #1;
    checks++; if ({refetch, stall, bus.op_ready, refetch_pc} !== {3'b001, 32'h0}) begin failures++; $display("FAIL tlbp_back_idle got=%h", {refetch, stall, bus.op_ready, refetch_pc}); end
    s_found = 1'b0;
    s_index = 4'd0;
  endtask

  task automatic test_tlbwi_wrap;
    int          we_cnt;
    int          stall_cnt;
    logic        seen_rf;
    logic [31:0] rf_pc;
    we_cnt    = 0;
    stall_cnt = 0;
    seen_rf   = 1'b0;
    rf_pc     = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (i == 0) begin
        bus.op_valid = 1'b1;
        bus.op_type  = OP_TLBWI;
        bus.op_pc    = 32'hFFFF_FFFC;
      end else begin
        bus.op_valid = 1'b0;
      end
      #1;
      if (tlb_we) we_cnt++;
      if (stall) stall_cnt++;
      if (refetch) begin seen_rf = 1'b1; rf_pc = refetch_pc; end
      if (i == 1) begin
        checks++; if ({tlb_we, p_wen, cp0_tlbr} !== 3'b100) begin failures++; $display("FAIL tlbwi_exec_strobes got=%b exp=100", {tlb_we, p_wen, cp0_tlbr}); end
      end
    end
    checks++; if (we_cnt !== 1) begin failures++; $display("FAIL tlbwi_we_cycles got=%0d exp=1", we_cnt); end
    checks++; if (stall_cnt !== 2) begin failures++; $display("FAIL tlbwi_stall_cycles got=%0d exp=2", stall_cnt); end
    checks++; if ({seen_rf, rf_pc} !== {1'b1, 32'h0000_0000}) begin failures++; $display("FAIL tlbwi_refetch_wrap got=%0h/%h exp=1/00000000", seen_rf, rf_pc); end
  endtask

  task automatic test_arb_starve;
    logic [1:0]  exp_g    [5] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    logic [19:0] exp_srch [5] = '{20'h12345, 20'h12345, 20'h12345, 20'hABCDE, 20'h12345};
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      bus.if_req  = 1'b1;
      bus.mem_req = 1'b1;
      bus.if_vpn  = 20'hABCDE;
      bus.mem_vpn = 20'h12345;
      #1;
      checks++; if ({bus.if_gnt, bus.mem_gnt} !== exp_g[i]) begin failures++; $display("FAIL arb_grant_c%0d got=%b exp=%b", i + 1, {bus.if_gnt, bus.mem_gnt}, exp_g[i]); end
      checks++; if ({s_vpn2, s_odd, s_asid} !== {exp_srch[i], 8'h3A}) begin failures++; $display("FAIL arb_search_c%0d got=%h exp=%h", i + 1, {s_vpn2, s_odd, s_asid}, {exp_srch[i], 8'h3A}); end
    end
    next_cycle();
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    #1;
    checks++; if ({bus.if_gnt, bus.mem_gnt, s_vpn2, s_odd, s_asid} !== 30'b0) begin failures++; $display("FAIL arb_idle_zero got=%h exp=0", {bus.if_gnt, bus.mem_gnt, s_vpn2, s_odd, s_asid}); end
  endtask

  task automatic test_tlbr_during_req;
    logic [1:0] exp_g [5] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      bus.if_req   = 1'b1;
      bus.mem_req  = 1'b1;
      bus.op_valid = (i == 0);
      bus.op_type  = OP_TLBR;
      bus.op_pc    = 32'h0000_4000;
      #1;
      checks++; if ({bus.if_gnt, bus.mem_gnt} !== exp_g[i]) begin failures++; $display("FAIL tlbr_grant_c%0d got=%b exp=%b", i, {bus.if_gnt, bus.mem_gnt}, exp_g[i]); end
      if (i == 1) begin
        checks++; if ({cp0_tlbr, tlb_we, p_wen, stall, s_vpn2} !== {4'b1001, 19'h0}) begin failures++; $display("FAIL tlbr_exec got=%h", {cp0_tlbr, tlb_we, p_wen, stall, s_vpn2}); end
      end
    end
    next_cycle();
    bus.if_req   = 1'b0;
    bus.mem_req  = 1'b0;
    bus.op_valid = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp_rdy = 7'b1001001;
    logic [6:0] exp_pw  = 7'b0010010;
    logic [6:0] exp_rf  = 7'b0100100;
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      bus.op_valid = (i < 4);
      bus.op_type  = OP_TLBP;
      bus.op_pc    = 32'h0000_2000;
      #1;
      checks++; if ({bus.op_ready, p_wen, refetch} !== {exp_rdy[i], exp_pw[i], exp_rf[i]}) begin
        failures++; $display("FAIL b2b_c%0d got=%b exp=%b", i, {bus.op_ready, p_wen, refetch}, {exp_rdy[i], exp_pw[i], exp_rf[i]});
      end
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic test_nop;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.op_valid = 1'b1;
      bus.op_type  = OP_NONE;
      #1;
      checks++; if ({bus.op_ready, stall, p_wen, tlb_we, cp0_tlbr} !== 5'b10000) begin failures++; $display("FAIL nop_c%0d got=%b exp=10000", i, {bus.op_ready, stall, p_wen, tlb_we, cp0_tlbr}); end
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic test_reset_exec;
    logic seen_rf;
    seen_rf = 1'b0;
    next_cycle();
    bus.op_valid = 1'b1;
    bus.op_type  = OP_TLBWI;
    bus.op_pc    = 32'h0000_3000;
    #1;
    checks++; if (bus.op_ready !== 1'b1) begin failures++; $display("FAIL rexec_accept got=%0h exp=1", bus.op_ready); end
    next_cycle();
    bus.op_valid = 1'b0;
    reset        = 1'b1;
    #1;
    checks++; if ({bus.op_ready, tlb_we, stall, refetch} !== 4'b1000) begin failures++; $display("FAIL rexec_reset_cycle got=%b exp=1000", {bus.op_ready, tlb_we, stall, refetch}); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      reset = 1'b0;
      #1;
      if (refetch) seen_rf = 1'b1;
      checks++; if ({bus.op_ready, stall, tlb_we} !== 3'b100) begin failures++; $display("FAIL rexec_after_c%0d got=%b exp=100", i, {bus.op_ready, stall, tlb_we}); end
    end
    checks++; if (seen_rf !== 1'b0) begin failures++; $display("FAIL rexec_no_refetch got=%0h exp=0", seen_rf); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    cp0_vpn2     = '0;
    cp0_asid     = '0;
    s_found      = 1'b0;
    s_index      = '0;
    bus.if_req   = 1'b0;
    bus.if_vpn   = '0;
    bus.mem_req  = 1'b0;
    bus.mem_vpn  = '0;
    bus.op_valid = 1'b0;
    bus.op_type  = OP_NONE;
    bus.op_pc    = '0;

    test_reset();
    test_tlbp();
    test_tlbwi_wrap();
    test_arb_starve();
    test_tlbr_during_req();
    test_back_to_back();
    test_nop();
    test_reset_exec();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
